// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console writer.
// Optional tab expansion is enabled by defining TEXT_CONSOLE_TAB_EN.
package text_console_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUT,
      ST_SCRL_RD,
      ST_SCRL_WR,
      ST_ROW_CLR,
      ST_SCR_CLR
   } state_t;

   // What to do with the cursor once a PUT write completes
   typedef enum logic [1:0] {
      PM_ADV,
      PM_BS,
      PM_TAB
   } put_mode_t;

   localparam logic [6:0] CC_LF  = 7'h0A;
   localparam logic [6:0] CC_CR  = 7'h0D;
   localparam logic [6:0] CC_BS  = 7'h08;
   localparam logic [6:0] CC_FF  = 7'h0C;
   localparam logic [6:0] CC_TAB = 7'h09;

   localparam int unsigned VRAM_WORDS = 30 * 80 / 4;

endpackage

// File: rtl/avl_word_master.sv
// Single-transfer Avalon-MM master: presents one held command and reports completion.
// The command registers upstream only change on o_done, so outputs stay stable under waitrequest.
module avl_word_master (
   input  logic        i_req,
   input  logic        i_rd,
   input  logic [9:0]  i_addr,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic [9:0]  o_m_addr,
   output logic        o_m_read,
   output logic        o_m_write,
   output logic [3:0]  o_m_byte_en,
   output logic [31:0] o_m_writedata,
   input  logic [31:0] i_m_readdata,
   input  logic        i_m_waitrequest
);

   assign o_done        = i_req & ~i_m_waitrequest;
   assign o_rdata       = i_m_readdata;
   assign o_m_read      = i_req & i_rd;
   assign o_m_write     = i_req & ~i_rd;
   assign o_m_addr      = i_req ? i_addr  : '0;
   assign o_m_byte_en   = i_req ? i_be    : '0;
   assign o_m_writedata = i_req ? i_wdata : '0;

endmodule

// File: rtl/text_console_writer.sv
// Streams characters into the 80x30 text VRAM with cursor, control codes and scrolling.
// Define TEXT_CONSOLE_TAB_EN to expand 0x09 into fill cells up to the next 8-column stop.
module text_console_writer #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 30,
   parameter logic [7:0]  FILL_CODE = 8'h00
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  CHAR_DATA,
   input  logic        CHAR_VALID,
   output logic        CHAR_READY,
   output logic        BUSY,
   output logic [6:0]  CURSOR_COL,
   output logic [4:0]  CURSOR_ROW,
   output logic [9:0]  M_ADDR,
   output logic        M_READ,
   output logic        M_WRITE,
   output logic [3:0]  M_BYTE_EN,
   output logic [31:0] M_WRITEDATA,
   input  logic [31:0] M_READDATA,
   input  logic        M_WAITREQUEST
);
   import text_console_pkg::*;

   localparam logic [9:0]  ROW_STEP  = 10'(COLS / 4);
   localparam logic [9:0]  LAST_MOVE = 10'(ROWS * COLS / 4 - COLS / 4 - 1);
   localparam logic [9:0]  LAST_WORD = 10'(ROWS * COLS / 4 - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
   localparam logic [31:0] FILL_WORD = {4{FILL_CODE}};

   function automatic logic [11:0] cell_idx(input logic [4:0] row, input logic [6:0] col);
      return 12'(row) * 12'(COLS) + 12'(col);
   endfunction

   state_t      r_state;
   put_mode_t   r_mode;
   logic [6:0]  r_col;
   logic [4:0]  r_row;
   logic        r_req;
   logic        r_rd;
   logic [9:0]  r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;

   logic        w_done;
   logic [31:0] w_rdata;
   logic [6:0]  w_col_nxt;
   logic [11:0] w_idx_cur;
   logic [11:0] w_idx_prev;
   logic [11:0] w_idx_next;

   assign w_col_nxt  = r_col + 7'd1;
   assign w_idx_cur  = cell_idx(r_row, r_col);
   assign w_idx_prev = cell_idx(r_row, r_col - 7'd1);
   assign w_idx_next = cell_idx(r_row, w_col_nxt);

   assign CHAR_READY = RESET_N & (r_state == ST_IDLE);
   assign BUSY       = (r_state != ST_IDLE);
   assign CURSOR_COL = r_col;
   assign CURSOR_ROW = r_row;

   avl_word_master u_master (
      .i_req           (r_req),
      .i_rd            (r_rd),
      .i_addr          (r_addr),
      .i_be            (r_be),
      .i_wdata         (r_wdata),
      .o_done          (w_done),
      .o_rdata         (w_rdata),
      .o_m_addr        (M_ADDR),
      .o_m_read        (M_READ),
      .o_m_write       (M_WRITE),
      .o_m_byte_en     (M_BYTE_EN),
      .o_m_writedata   (M_WRITEDATA),
      .i_m_readdata    (M_READDATA),
      .i_m_waitrequest (M_WAITREQUEST)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_IDLE;
         r_mode  <= PM_ADV;
         r_col   <= '0;
         r_row   <= '0;
         r_req   <= 1'b0;
         r_rd    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (CHAR_VALID) begin
               if (!CHAR_DATA[7] && (CHAR_DATA[6:0] < 7'h20)) begin
                  case (CHAR_DATA[6:0])
                     CC_LF: if (r_row == LAST_ROW) begin
                        r_req   <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= ROW_STEP;
                        r_be    <= 4'hF;
                        r_state <= ST_SCRL_RD;
                     end else begin
                        r_col <= '0;
                        r_row <= r_row + 5'd1;
                     end
                     CC_CR: r_col <= '0;
                     CC_BS: if (r_col != '0) begin
                        r_req   <= 1'b1;
                        r_rd    <= 1'b0;
                        r_addr  <= w_idx_prev[11:2];
                        r_be    <= 4'b0001 << w_idx_prev[1:0];
                        r_wdata <= FILL_WORD;
                        r_mode  <= PM_BS;
                        r_state <= ST_PUT;
                     end
                     CC_FF: begin
                        r_req   <= 1'b1;
                        r_rd    <= 1'b0;
                        r_addr  <= '0;
                        r_be    <= 4'hF;
                        r_wdata <= FILL_WORD;
                        r_state <= ST_SCR_CLR;
                     end
`ifdef TEXT_CONSOLE_TAB_EN
                     CC_TAB: begin
                        r_req   <= 1'b1;
                        r_rd    <= 1'b0;
                        r_addr  <= w_idx_cur[11:2];
                        r_be    <= 4'b0001 << w_idx_cur[1:0];
                        r_wdata <= FILL_WORD;
                        r_mode  <= PM_TAB;
                        r_state <= ST_PUT;
                     end
`endif
                     default: ;
                  endcase
               end else begin
                  r_req   <= 1'b1;
                  r_rd    <= 1'b0;
                  r_addr  <= w_idx_cur[11:2];
                  r_be    <= 4'b0001 << w_idx_cur[1:0];
                  r_wdata <= {4{CHAR_DATA}};
                  r_mode  <= PM_ADV;
                  r_state <= ST_PUT;
               end
            end

            ST_PUT: if (w_done) begin
               if (r_mode == PM_BS) begin
                  r_col   <= r_col - 7'd1;
                  r_req   <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_col == LAST_COL) begin
                  // End of line: the cursor only moves once any scroll has finished
                  if (r_row == LAST_ROW) begin
                     r_rd    <= 1'b1;
                     r_addr  <= ROW_STEP;
                     r_be    <= 4'hF;
                     r_state <= ST_SCRL_RD;
                  end else begin
                     r_col   <= '0;
                     r_row   <= r_row + 5'd1;
                     r_req   <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else if ((r_mode == PM_TAB) && (w_col_nxt[2:0] != 3'd0)) begin
                  r_col  <= w_col_nxt;
                  r_addr <= w_idx_next[11:2];
                  r_be   <= 4'b0001 << w_idx_next[1:0];
               end else begin
                  r_col   <= w_col_nxt;
                  r_req   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_SCRL_RD: if (w_done) begin
               r_wdata <= w_rdata;
               r_rd    <= 1'b0;
               r_addr  <= r_addr - ROW_STEP;
               r_state <= ST_SCRL_WR;
            end

            ST_SCRL_WR: if (w_done) begin
               if (r_addr == LAST_MOVE) begin
                  r_addr  <= r_addr + 10'd1;
                  r_wdata <= FILL_WORD;
                  r_state <= ST_ROW_CLR;
               end else begin
                  r_rd    <= 1'b1;
                  r_addr  <= r_addr + ROW_STEP + 10'd1;
                  r_state <= ST_SCRL_RD;
               end
            end

            ST_ROW_CLR: if (w_done) begin
               if (r_addr == LAST_WORD) begin
                  r_col   <= '0;
                  r_req   <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_addr <= r_addr + 10'd1;
               end
            end

            ST_SCR_CLR: if (w_done) begin
               if (r_addr == LAST_WORD) begin
                  r_col   <= '0;
                  r_row   <= '0;
                  r_req   <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_addr <= r_addr + 10'd1;
               end
            end

            default: begin
               r_req   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a VRAM slave model and transfer log.
// Tab expectations follow TEXT_CONSOLE_TAB_EN.
module tb_text_console_writer;
   import text_console_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [7:0]  CHAR_DATA = '0;
   logic        CHAR_VALID = 1'b0;
   logic        CHAR_READY;
   logic        BUSY;
   logic [6:0]  CURSOR_COL;
   logic [4:0]  CURSOR_ROW;
   logic [9:0]  M_ADDR;
   logic        M_READ;
   logic        M_WRITE;
   logic [3:0]  M_BYTE_EN;
   logic [31:0] M_WRITEDATA;
   logic [31:0] M_READDATA;
   logic        M_WAITREQUEST = 1'b0;

   text_console_writer #(.COLS(80), .ROWS(30), .FILL_CODE(8'h00)) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .CHAR_DATA     (CHAR_DATA),
      .CHAR_VALID    (CHAR_VALID),
      .CHAR_READY    (CHAR_READY),
      .BUSY          (BUSY),
      .CURSOR_COL    (CURSOR_COL),
      .CURSOR_ROW    (CURSOR_ROW),
      .M_ADDR        (M_ADDR),
      .M_READ        (M_READ),
      .M_WRITE       (M_WRITE),
      .M_BYTE_EN     (M_BYTE_EN),
      .M_WRITEDATA   (M_WRITEDATA),
      .M_READDATA    (M_READDATA),
      .M_WAITREQUEST (M_WAITREQUEST)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rd;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } xfer_t;

   logic [31:0] vram [0:599];
   logic [31:0] expv [0:599];
   xfer_t       log_q [$];
   int          load_kind = 0;
   int          n_total = 0;
   int          n_bad = 0;
   int          n_unstable = 0;
   int          n_stalls = 0;
   bit          wq_rand = 1'b0;
   logic        p_stall = 1'b0;
   logic [47:0] p_bus = '0;

   assign M_READDATA = (M_ADDR < 10'd600) ? vram[M_ADDR] : 32'hDEAD_BEEF;

   function automatic logic [31:0] pat(input int k, input int w);
      return (32'(k) << 24) | 32'(w * 7 + 1);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Slave side: bulk loads, write merge, transfer log and stall-stability monitor
   always @(posedge CLK) begin
      if (load_kind == 1) for (int w = 0; w < 600; w++) vram[w] <= '0;
      else if (load_kind >= 2) for (int w = 0; w < 600; w++) vram[w] <= pat(load_kind, w);
      if (RESET_N && !M_WAITREQUEST && (M_READ || M_WRITE)) begin
         log_q.push_back({M_READ, M_ADDR, M_BYTE_EN, M_READ ? M_READDATA : M_WRITEDATA});
         if (M_WRITE && (M_ADDR < 10'd600))
            vram[M_ADDR] <= merge(vram[M_ADDR], M_WRITEDATA, M_BYTE_EN);
      end
      if (p_stall && ({M_READ, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA} !== p_bus))
         n_unstable++;
      p_stall = RESET_N && M_WAITREQUEST && (M_READ || M_WRITE);
      p_bus   = {M_READ, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA};
      if (p_stall) n_stalls++;
   end

   initial begin
      int burst;
      burst = 0;
      forever begin
         @(negedge CLK);
         if (!wq_rand) begin
            M_WAITREQUEST = 1'b0;
            burst = 0;
         end else if (burst > 0) begin
            M_WAITREQUEST = 1'b1;
            burst--;
         end else if ($urandom_range(0, 2) == 0) begin
            M_WAITREQUEST = 1'b1;
            burst = int'($urandom_range(0, 4));
         end else begin
            M_WAITREQUEST = 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_cursor(input string tag, input int row, input int col);
      check_eq(tag, {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'(row), 7'(col)});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((BUSY || !CHAR_READY) && (n < 20000)) begin
         @(negedge CLK);
         n++;
      end
      check_eq({tag, "_in_time"}, 32'(n < 20000), 32'd1);
   endtask

   task automatic send(input logic [7:0] b);
      wait_idle("send");
      CHAR_DATA  = b;
      CHAR_VALID = 1'b1;
      @(negedge CLK);
      CHAR_VALID = 1'b0;
   endtask

   task automatic load(input int k);
      load_kind = k;
      @(negedge CLK);
      load_kind = 0;
   endtask

   task automatic build_shift(input int k, input logic [7:0] put599);
      for (int w = 0; w < 600; w++) expv[w] = pat(k, w);
      if (put599 != 8'h00) expv[599][31:24] = put599;
      for (int w = 0; w < 580; w++) expv[w] = expv[w + 20];
      for (int w = 580; w < 600; w++) expv[w] = '0;
   endtask

   function automatic int vram_diffs();
      int d;
      d = 0;
      for (int w = 0; w < 600; w++) if (vram[w] !== expv[w]) d++;
      return d;
   endfunction

`ifdef TEXT_CONSOLE_TAB_EN
   logic [9:0] tab_word [0:4] = '{10'd0, 10'd1, 10'd1, 10'd1, 10'd1};
   logic [3:0] tab_be   [0:4] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      int n;
      int sz;

      // Reset state
      RESET_N = 1'b0;
      load(1);
      repeat (2) @(negedge CLK);
      check_eq("rst_ready", CHAR_READY, 0);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_bus", {M_READ, M_WRITE, M_BYTE_EN, M_ADDR}, 0);
      check_eq("rst_wdata", M_WRITEDATA, 0);
      check_cursor("rst_cursor", 0, 0);
      RESET_N = 1'b1;
      @(negedge CLK);
      check_eq("ready_after_rst", CHAR_READY, 1);

      // "AB" with latency
      log_q.delete();
      send(8'h41);
      check_eq("A_rw", {M_WRITE, M_READ}, 2'b10);
      check_eq("A_addr", M_ADDR, 0);
      check_eq("A_be", M_BYTE_EN, 4'b0001);
      check_eq("A_data", M_WRITEDATA, 32'h41414141);
      check_eq("A_ready_n1", CHAR_READY, 0);
      @(negedge CLK);
      check_eq("A_ready_n2", CHAR_READY, 1);
      check_eq("A_write_off", M_WRITE, 0);
      check_cursor("A_cursor", 0, 1);
      send(8'h42);
      check_eq("B_be", M_BYTE_EN, 4'b0010);
      check_eq("B_data", M_WRITEDATA, 32'h42424242);
      @(negedge CLK);
      check_eq("B_ready_n2", CHAR_READY, 1);
      check_cursor("AB_cursor", 0, 2);
      check_eq("AB_nxfer", log_q.size(), 2);
      check_eq("AB_vram0", vram[0], 32'h00004241);

      // CR: ready again next cycle, no traffic
      send(8'h0D);
      check_eq("CR_ready", CHAR_READY, 1);
      check_eq("CR_busy", BUSY, 0);
      check_cursor("CR_cursor", 0, 0);
      check_eq("CR_nxfer", log_q.size(), 2);

      // LF x3 then BS at column 0
      repeat (3) send(8'h0A);
      send(8'h08);
      @(negedge CLK);
      check_cursor("BS0_cursor", 3, 0);
      check_eq("BS0_nxfer", log_q.size(), 2);

      // BS at (3,5)
      send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
      wait_idle("hello");
      check_cursor("hello_cursor", 3, 5);
      log_q.delete();
      send(8'h08);
      wait_idle("bs");
      check_eq("BS_nxfer", log_q.size(), 1);
      check_eq("BS_xfer", {log_q[0].rd, log_q[0].addr, log_q[0].be}, {1'b0, 10'd61, 4'b0001});
      check_eq("BS_data", log_q[0].data, 32'h0);
      check_cursor("BS_cursor", 3, 4);

      // Ignored control codes, then bit7 set makes 0x0A printable
      log_q.delete();
      send(8'h01);
      send(8'h1F);
      wait_idle("ign");
      check_eq("ign_nxfer", log_q.size(), 0);
      check_cursor("ign_cursor", 3, 4);
      send(8'h8A);
      check_eq("iv_data", M_WRITEDATA, 32'h8A8A8A8A);
      check_eq("iv_addr", M_ADDR, 61);
      wait_idle("iv");
      check_cursor("iv_cursor", 3, 5);

      // Form feed clears the whole screen
      log_q.delete();
      send(8'h0C);
      n = 0;
      while (BUSY && (n < 5000)) begin
         n++;
         @(negedge CLK);
      end
      check_eq("FF_busy_cycles", n, 600);
      check_eq("FF_nxfer", log_q.size(), VRAM_WORDS);
      errs = 0;
      for (int i = 0; i < log_q.size(); i++)
         if (log_q[i] !== {1'b0, 10'(i), 4'hF, 32'h0}) errs++;
      check_eq("FF_seq", errs, 0);
      check_cursor("FF_cursor", 0, 0);
      for (int w = 0; w < 600; w++) expv[w] = '0;
      check_eq("FF_vram", vram_diffs(), 0);

      // Tab from (0,3)
      repeat (3) send(8'h41);
      wait_idle("pretab");
      log_q.delete();
      send(8'h09);
      wait_idle("tab");
`ifdef TEXT_CONSOLE_TAB_EN
      check_eq("TAB_nxfer", log_q.size(), 5);
      errs = 0;
      for (int i = 0; i < 5; i++)
         if (log_q[i] !== {1'b0, tab_word[i], tab_be[i], 32'h0}) errs++;
      check_eq("TAB_seq", errs, 0);
      check_cursor("TAB_cursor", 0, 8);
`else
      check_eq("TAB_nxfer", log_q.size(), 0);
      check_cursor("TAB_cursor", 0, 3);
`endif

      // Move to (29,79) and print: scroll without stalls
      send(8'h0D);
      repeat (29) send(8'h0A);
      repeat (79) send(8'h2E);
      wait_idle("fill");
      check_cursor("pre_scroll_cursor", 29, 79);
      load(2);
      build_shift(2, 8'h5A);
      log_q.delete();
      send(8'h5A);
      wait_idle("scroll1");
      sz = log_q.size();
      check_eq("SC1_nxfer", sz, 1181);
      check_eq("SC1_put", {log_q[0].rd, log_q[0].addr, log_q[0].be}, {1'b0, 10'd599, 4'b1000});
      check_eq("SC1_put_data", log_q[0].data, 32'h5A5A5A5A);
      errs = 0;
      if (sz != 1181) errs = 9999;
      else begin
         for (int i = 0; i < 580; i++) begin
            if (!log_q[1 + 2*i].rd || (log_q[1 + 2*i].addr != 10'(i + 20))) errs++;
            if ((log_q[2 + 2*i].rd) || (log_q[2 + 2*i].addr != 10'(i)) ||
                (log_q[2 + 2*i].be != 4'hF) || (log_q[2 + 2*i].data != log_q[1 + 2*i].data))
               errs++;
         end
         for (int j = 0; j < 20; j++)
            if (log_q[1161 + j] !== {1'b0, 10'(580 + j), 4'hF, 32'h0}) errs++;
      end
      check_eq("SC1_seq", errs, 0);
      check_eq("SC1_vram", vram_diffs(), 0);
      check_cursor("SC1_cursor", 29, 0);

      // LF at the last row with random waitrequest bursts
      load(3);
      build_shift(3, 8'h00);
      log_q.delete();
      wq_rand = 1'b1;
      send(8'h0A);
      wait_idle("scroll2");
      wq_rand = 1'b0;
      @(negedge CLK);
      check_eq("SC2_nxfer", log_q.size(), 1180);
      check_eq("SC2_vram", vram_diffs(), 0);
      check_eq("SC2_stable", n_unstable, 0);
      check_eq("SC2_stalled", 32'(n_stalls > 0), 1);
      check_cursor("SC2_cursor", 29, 0);

      // Reset in the middle of a scroll
      send(8'h0A);
      repeat (100) @(negedge CLK);
      check_eq("mid_busy", BUSY, 1);
      RESET_N = 1'b0;
      #1;
      check_eq("mid_rst_bus", {M_READ, M_WRITE, M_BYTE_EN, M_ADDR}, 0);
      check_eq("mid_rst_wdata", M_WRITEDATA, 0);
      check_eq("mid_rst_busy", BUSY, 0);
      check_eq("mid_rst_ready", CHAR_READY, 0);
      check_cursor("mid_rst_cursor", 0, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      sz = log_q.size();
      repeat (5) @(negedge CLK);
      check_eq("post_rst_busy", BUSY, 0);
      check_eq("post_rst_ready", CHAR_READY, 1);
      check_eq("post_rst_no_resume", log_q.size(), sz);
      check_cursor("post_rst_cursor", 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
